memaccess: RTL and testbench
============================

MEMACCESS -- requirements
Module: memaccess

Interface
REQ-001 Parameter DMEM_AW, default 32, SHALL set the data-memory address width; the bus address is i_data_alures[DMEM_AW-1:0].
REQ-002 i_clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 i_rst  in  1  SHALL be a synchronous, active-high reset sampled on the rising edge of i_clk.
REQ-004 i_data_alures in 32, i_data_rt in 32, i_addr_regdst in 5 SHALL be the registered address/result, store data and destination register from the execute stage.
REQ-005 i_con_Mmemread, i_con_Mmemwrite in 1, i_con_Wloadmux in 2, i_con_Wmemtoreg, i_con_Wregwrite in 1 SHALL be the registered execute-stage controls.
REQ-006 o_dmem_req out 1, o_dmem_we out 1, o_dmem_addr out DMEM_AW, o_dmem_wdata out 32, o_dmem_be out 4 SHALL form the data-memory request.
REQ-007 i_dmem_ready in 1, i_dmem_rdata in 32 SHALL be the memory completion strobe and read data, valid in the cycle i_dmem_ready=1.
REQ-008 o_stall out 1 SHALL tell upstream stages to hold their registers.
REQ-009 o_data_wbres out 32, o_data_alures out 32, o_addr_regdst out 5, o_con_Wregwrite out 1 SHALL be the registered memory/writeback outputs; o_data_alures, o_addr_regdst and o_con_Wregwrite also feed execute-stage forwarding.
REQ-010 o_err out 1 SHALL flag a misaligned access (see Configuration).

Function
REQ-011 Access = i_con_Mmemread | i_con_Mmemwrite; both high SHALL be treated as a write.
REQ-012 FSM states SHALL be IDLE and WAIT.
REQ-013 IDLE: with an access, o_dmem_req=1 combinationally; if i_dmem_ready=1 in that cycle, the access completes (zero-wait); otherwise the next state is WAIT.
REQ-014 WAIT: o_dmem_req SHALL remain 1 with addr/we/wdata/be unchanged; on i_dmem_ready=1 the access completes and the next state is IDLE.
REQ-015 o_stall SHALL equal o_dmem_req & ~i_dmem_ready; upstream holds all i_* inputs stable while o_stall=1.
REQ-016 i_con_Wloadmux encoding SHALL be 00 word, 01 byte signed, 10 half signed, 11 byte unsigned; stores use 00 word, 01/11 byte, 10 half.
REQ-017 o_dmem_addr SHALL carry the address with bits [1:0] forced to 0.
REQ-018 Little-endian lanes: byte be=4'b0001<<addr[1:0] and wdata={4{rt[7:0]}}; half be=addr[1]?1100:0011 and wdata={2{rt[15:0]}}; word be=1111 and wdata=rt.
REQ-019 Load extraction: byte=rdata[8*addr[1:0]+:8], half=addr[1]?rdata[31:16]:rdata[15:0], then sign- or zero-extended per REQ-016.
REQ-020 Each rising edge without stall SHALL load o_data_alures<=i_data_alures, o_addr_regdst<=i_addr_regdst, o_con_Wregwrite<=i_con_Wregwrite, and o_data_wbres<=(i_con_Wmemtoreg & read ? extracted load : i_data_alures).
REQ-021 Each stalled edge SHALL load a bubble: o_con_Wregwrite<=0; the data outputs hold their values.
REQ-022 No access pending: o_dmem_req=0, o_stall=0, and the stage SHALL pass through with one-cycle latency.
REQ-023 Back-to-back accesses SHALL issue the next request in the cycle after completion, with no idle cycle in between.

Reset
REQ-024 While i_rst=1, o_dmem_req and o_stall SHALL be forced to 0 combinationally.
REQ-025 On a reset edge, the state SHALL go to IDLE and o_data_wbres, o_data_alures, o_addr_regdst, o_con_Wregwrite and o_err SHALL go to 0.
REQ-026 Reset asserted in WAIT SHALL abandon the access; a late i_dmem_ready after reset SHALL be ignored.

Configuration
REQ-027 With MEMACCESS_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no request and SHALL NOT stall; the next edge sets o_err=1 for one cycle and o_con_Wregwrite=0.
REQ-028 Without MEMACCESS_ALIGN_CHECK_EN, no alignment check SHALL be made and o_err SHALL be tied to 0; a misaligned half/word uses lanes per REQ-018/019 with the low bits ignored as applicable.

Verification
REQ-029 ALU op alures=0x0000_0010, regwrite=1, memtoreg=0 -> no req, next cycle wbres=0x10, Wregwrite=1.
REQ-030 lb signed addr=0x103, rdata=0x80xx_xxxx, zero-wait ready -> req one cycle, o_dmem_addr=0x100, wbres=0xFFFF_FF80, stall=0.
REQ-031 sh addr=0x202, rt=0x1234_ABCD, ready delayed 3 cycles -> stall high 3 cycles, be=1100, wdata=0xABCD_ABCD stable throughout, three bubbles (Wregwrite=0).
REQ-032 lw addr=0x40 in WAIT, i_rst pulsed, ready arrives later -> req=0 in reset, outputs 0, late ready ignored.
REQ-033 With MEMACCESS_ALIGN_CHECK_EN: lw addr=0x41 -> no req, o_err=1 one cycle, Wregwrite=0; without the macro, the same stimulus issues a req with addr=0x40 and o_err=0.
REQ-034 Two consecutive lbu operations (0x0, 0x1), rdata=0x0000_A5C3, zero-wait -> wbres=0xC3 then 0xA5 on consecutive cycles.

Source files
------------

// File: rtl/memaccess_if.sv
// Data-memory request/response bus between the memory-access stage (master)
// and the data memory (slave). req/we/addr/wdata/be are held stable until the
// cycle in which ready is high; rdata is valid only in that cycle.
interface memaccess_if #(
  parameter int DMEM_AW = 32
) ();
  logic               req;
  logic               we;
  logic [DMEM_AW-1:0] addr;
  logic [31:0]        wdata;
  logic [3:0]         be;
  logic               ready;
  logic [31:0]        rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/memaccess.sv
// Memory-access pipeline stage: issues byte/half/word loads and stores on the
// data-memory bus, stalls upstream until the memory completes, extracts and
// extends load data, and registers the writeback result.
// Optional feature: define MEMACCESS_ALIGN_CHECK_EN to suppress misaligned
// half/word accesses and flag them on o_err; otherwise o_err is tied to 0.
module memaccess #(
  parameter int DMEM_AW = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data_alures,
  input  logic [31:0] i_data_rt,
  input  logic [4:0]  i_addr_regdst,
  input  logic        i_con_Mmemread,
  input  logic        i_con_Mmemwrite,
  input  logic [1:0]  i_con_Wloadmux,
  input  logic        i_con_Wmemtoreg,
  input  logic        i_con_Wregwrite,
  memaccess_if.master dmem,
  output logic        o_stall,
  output logic [31:0] o_data_wbres,
  output logic [31:0] o_data_alures,
  output logic [4:0]  o_addr_regdst,
  output logic        o_con_Wregwrite,
  output logic        o_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic        req_c;
  logic        access, is_read;
  logic        is_byte, is_half, is_word;
  logic        misalign;
  logic [1:0]  lane;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  logic [31:0] wbres_q, wbres_d;
  logic [31:0] alures_q, alures_d;
  logic [4:0]  regdst_q, regdst_d;
  logic        regwrite_q, regwrite_d;

  // A simultaneous read and write is treated as a write.
  assign access  = i_con_Mmemread | i_con_Mmemwrite;
  assign is_read = i_con_Mmemread & ~i_con_Mmemwrite;
  assign is_byte = i_con_Wloadmux[0];
  assign is_half = (i_con_Wloadmux == 2'b10);
  assign is_word = (i_con_Wloadmux == 2'b00);
  assign lane    = i_data_alures[1:0];

`ifdef MEMACCESS_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign misalign = access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

  // Error pulse for one cycle after a suppressed misaligned access.
  always_comb begin
    err_d = misalign & ~o_stall;
  end

  // Error flag register.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign misalign = 1'b0;
  assign o_err    = 1'b0;
`endif

  // Request FSM: IDLE issues on a fresh access, WAIT holds until ready.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_c = access & ~misalign;
        if (req_c && !dmem.ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (dmem.ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_rst) req_c = 1'b0;
  end

  // Store lane enables and replicated write data (little-endian).
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_data_rt;
    if (is_byte) begin
      be_c    = 4'b0001 << lane;
      wdata_c = {4{i_data_rt[7:0]}};
    end else if (is_half) begin
      be_c    = lane[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{i_data_rt[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = dmem.rdata[7:0];
      2'd1:    byte_sel = dmem.rdata[15:8];
      2'd2:    byte_sel = dmem.rdata[23:16];
      default: byte_sel = dmem.rdata[31:24];
    endcase
    half_sel = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (i_con_Wloadmux)
      2'b00:   load_val = dmem.rdata;
      2'b01:   load_val = {{24{byte_sel[7]}}, byte_sel};
      2'b10:   load_val = {{16{half_sel[15]}}, half_sel};
      default: load_val = {24'd0, byte_sel};
    endcase
  end

  assign dmem.req   = req_c;
  assign dmem.we    = i_con_Mmemwrite;
  assign dmem.addr  = {i_data_alures[DMEM_AW-1:2], 2'b00};
  assign dmem.be    = be_c;
  assign dmem.wdata = wdata_c;
  assign o_stall    = req_c & ~dmem.ready;

  // Writeback register inputs: advance when not stalled, bubble otherwise.
  always_comb begin
    wbres_d    = wbres_q;
    alures_d   = alures_q;
    regdst_d   = regdst_q;
    regwrite_d = 1'b0;
    if (!o_stall) begin
      alures_d   = i_data_alures;
      regdst_d   = i_addr_regdst;
      regwrite_d = i_con_Wregwrite & ~misalign;
      wbres_d    = (i_con_Wmemtoreg & is_read) ? load_val : i_data_alures;
    end
  end

  // State and writeback registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wbres_q    <= 32'd0;
      alures_q   <= 32'd0;
      regdst_q   <= 5'd0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbres_q    <= wbres_d;
      alures_q   <= alures_d;
      regdst_q   <= regdst_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign o_data_wbres    = wbres_q;
  assign o_data_alures   = alures_q;
  assign o_addr_regdst   = regdst_q;
  assign o_con_Wregwrite = regwrite_q;

endmodule

// File: tb/tb_memaccess.sv
// Bench for memaccess: directed vectors, a behavioural model checked every
// cycle, and literal expectations for the key scenarios.
module tb_memaccess;

`ifdef MEMACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] alures, rt;
  logic [4:0]  regdst;
  logic        mread, mwrite, m2r, rw;
  logic [1:0]  lmux;
  logic        stall, wrw_o, err_o;
  logic [31:0] wbres_o, alu_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_err    = 0;

  memaccess_if #(.DMEM_AW(32)) dmem ();

  memaccess #(.DMEM_AW(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_data_alures  (alures),
    .i_data_rt      (rt),
    .i_addr_regdst  (regdst),
    .i_con_Mmemread (mread),
    .i_con_Mmemwrite(mwrite),
    .i_con_Wloadmux (lmux),
    .i_con_Wmemtoreg(m2r),
    .i_con_Wregwrite(rw),
    .dmem           (dmem),
    .o_stall        (stall),
    .o_data_wbres   (wbres_o),
    .o_data_alures  (alu_o),
    .o_addr_regdst  (rd_o),
    .o_con_Wregwrite(wrw_o),
    .o_err          (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] m_be(input logic [1:0] mux, input logic [31:0] a);
    if (mux == 2'b00) return 4'hF;
    if (mux == 2'b10) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] mux, input logic [31:0] d);
    if (mux == 2'b00) return d;
    if (mux == 2'b10) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] mux, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    if (mux == 2'b00) return rd;
    if (mux == 2'b10) begin
      v = (a % 4 >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
      return (v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
    end
    v = (rd >> (8 * (a % 4))) & 32'hFF;
    if (mux == 2'b01 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic bit m_mis(input logic [1:0] mux, input logic [31:0] a, input bit acc);
    return ALIGN && acc && ((mux == 2'b10 && (a % 2) != 0) || (mux == 2'b00 && (a % 4) != 0));
  endfunction

  bit          armed = 1'b0;
  logic [31:0] e_wbres, e_alu;
  logic [4:0]  e_rd;
  logic        e_wrw, e_err;

  // Model of the registered outputs, advanced on every rising edge.
  always @(posedge clk) begin
    bit acc, mis, req_m;
    acc   = mread | mwrite;
    mis   = m_mis(lmux, alures, acc);
    req_m = !rst && acc && !mis;
    if (rst) begin
      e_wbres = 0; e_alu = 0; e_rd = 0; e_wrw = 0; e_err = 0;
    end else if (req_m && !dmem.ready) begin
      e_wrw = 0; e_err = 0;
    end else begin
      e_alu   = alures;
      e_rd    = regdst;
      e_wrw   = rw && !mis;
      e_err   = mis;
      e_wbres = (m2r && mread && !mwrite) ? m_load(lmux, alures, dmem.rdata) : alures;
    end
    armed = 1'b1;
  end

  // Compare process: every cycle, well clear of the rising edge.
  always @(negedge clk) begin
    bit acc, req_m;
    #3;
    acc   = mread | mwrite;
    req_m = !rst && acc && !m_mis(lmux, alures, acc);
    chk("m_req", {31'd0, dmem.req}, {31'd0, req_m});
    chk("m_stall", {31'd0, stall}, {31'd0, req_m && !dmem.ready});
    if (req_m) begin
      chk("m_addr", dmem.addr, alures & 32'hFFFF_FFFC);
      chk("m_we", {31'd0, dmem.we}, {31'd0, mwrite});
      chk("m_be", {28'd0, dmem.be}, {28'd0, m_be(lmux, alures)});
      chk("m_wdata", dmem.wdata, m_wdata(lmux, rt));
    end
    if (armed) begin
      chk("m_wbres", wbres_o, e_wbres);
      chk("m_alures", alu_o, e_alu);
      chk("m_regdst", {27'd0, rd_o}, {27'd0, e_rd});
      chk("m_wregwrite", {31'd0, wrw_o}, {31'd0, e_wrw});
      chk("m_err", {31'd0, err_o}, {31'd0, e_err});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    alures = 0; rt = 0; regdst = 0; mread = 0; mwrite = 0;
    lmux = 0; m2r = 0; rw = 0; dmem.ready = 1'b0; dmem.rdata = 0;
  endtask

  task automatic load(input logic [1:0] mux, input logic [31:0] a, input logic [31:0] rd,
                      input logic rdy);
    idle_in();
    mread = 1; m2r = 1; rw = 1; lmux = mux; alures = a; regdst = 5'd7;
    dmem.rdata = rd; dmem.ready = rdy;
  endtask

  initial begin
    idle_in();
    rst = 1; mread = 1; alures = 32'h40;
    tick(); #1;
    chk("rst_req", {31'd0, dmem.req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("rst_wbres", wbres_o, 32'd0);
    chk("rst_wrw", {31'd0, wrw_o}, 32'd0);
    rst = 0;

    // ALU result pass-through
    idle_in(); alures = 32'h10; rw = 1; regdst = 5'd3; #1;
    chk("alu_req", {31'd0, dmem.req}, 32'd0);
    tick();
    chk("alu_wbres", wbres_o, 32'h10);
    chk("alu_wrw", {31'd0, wrw_o}, 32'd1);

    // lb signed, zero-wait
    load(2'b01, 32'h103, 32'h8012_3456, 1'b1); #1;
    chk("lb_req", {31'd0, dmem.req}, 32'd1);
    chk("lb_addr", dmem.addr, 32'h100);
    chk("lb_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lb_wbres", wbres_o, 32'hFFFF_FF80);

    // sh with three wait cycles
    idle_in(); mwrite = 1; lmux = 2'b10; alures = 32'h202; rt = 32'h1234_ABCD; rw = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_stall", {31'd0, stall}, 32'd1);
      chk("sh_be", {28'd0, dmem.be}, 32'hC);
      chk("sh_wdata", dmem.wdata, 32'hABCD_ABCD);
      tick();
      chk("sh_bubble", {31'd0, wrw_o}, 32'd0);
    end
    dmem.ready = 1'b1; #1;
    chk("sh_done_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sh_wrw", {31'd0, wrw_o}, 32'd1);
    chk("sh_wbres", wbres_o, 32'h202);

    // lbu back-to-back
    load(2'b11, 32'h0, 32'h0000_A5C3, 1'b1);
    tick();
    chk("lbu0_wbres", wbres_o, 32'hC3);
    alures = 32'h1; #1;
    chk("lbu1_req", {31'd0, dmem.req}, 32'd1);
    tick();
    chk("lbu1_wbres", wbres_o, 32'hA5);

    // lh signed upper half
    load(2'b10, 32'h6, 32'h8001_7FFF, 1'b1);
    tick();
    chk("lh_wbres", wbres_o, 32'hFFFF_8001);

    // read+write together behaves as a byte store
    idle_in(); mread = 1; mwrite = 1; m2r = 1; rw = 1; lmux = 2'b01;
    alures = 32'h301; rt = 32'h5A; dmem.ready = 1'b1; dmem.rdata = 32'hDEAD_BEEF; #1;
    chk("rw_we", {31'd0, dmem.we}, 32'd1);
    chk("rw_be", {28'd0, dmem.be}, 32'h2);
    chk("rw_wdata", dmem.wdata, 32'h5A5A_5A5A);
    tick();
    chk("rw_wbres", wbres_o, 32'h301);

    // lw abandoned by reset while waiting
    load(2'b00, 32'h40, 32'h1111_2222, 1'b0); #1;
    chk("lwr_stall", {31'd0, stall}, 32'd1);
    tick();
    rst = 1; #1;
    chk("lwr_rst_req", {31'd0, dmem.req}, 32'd0);
    chk("lwr_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 0; idle_in(); dmem.ready = 1'b1; dmem.rdata = 32'h1111_2222; #1;
    chk("lwr_late_req", {31'd0, dmem.req}, 32'd0);
    chk("lwr_late_stall", {31'd0, stall}, 32'd0);
    chk("lwr_wbres", wbres_o, 32'd0);
    chk("lwr_alures", alu_o, 32'd0);
    tick();
    idle_in();
    tick();

    // misaligned lw
    load(2'b00, 32'h41, 32'hCAFE_F00D, 1'b1); #1;
    if (ALIGN) begin
      chk("mis_req", {31'd0, dmem.req}, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("mis_err", {31'd0, err_o}, 32'd1);
      chk("mis_wrw", {31'd0, wrw_o}, 32'd0);
      idle_in();
      tick();
      chk("mis_err_clr", {31'd0, err_o}, 32'd0);
    end else begin
      chk("mis_req", {31'd0, dmem.req}, 32'd1);
      chk("mis_addr", dmem.addr, 32'h40);
      tick();
      chk("mis_err", {31'd0, err_o}, 32'd0);
      chk("mis_wbres", wbres_o, 32'hCAFE_F00D);
      idle_in();
      tick();
    end

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
